// File: rtl/ren_chain_responder.sv
// Read-enable chain responder: storage reads through a LAT-cycle pipeline into a credit-limited response FIFO.
// Optional REN_RESP_CLR_EN: storage cleared on reset and by an all-ones write to the all-ones address.
module ren_chain_responder #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int LAT    = 2,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     io_in_ren,
    input  logic [ADDR_W-1:0]        io_in_addr,
    output logic                     io_in_rdy,
    input  logic                     io_wen,
    input  logic [ADDR_W-1:0]        io_waddr,
    input  logic [DATA_W-1:0]        io_wdata,
    output logic                     io_out_valid,
    input  logic                     io_out_ready,
    output logic [DATA_W-1:0]        io_out_data,
    output logic [$clog2(DEPTH):0]   io_count,
    output logic                     io_err
);

    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int FW    = $clog2(DEPTH);
    localparam int WORDS = 1 << ADDR_W;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [DATA_W-1:0] mem_q [WORDS];
    logic [DATA_W-1:0] mem_d [WORDS];
    logic [DATA_W-1:0] rd_data;
    logic              accept;
    logic              drop;
    logic              pop;
    logic              push_v;
    logic [DATA_W-1:0] push_d;

    logic [DATA_W-1:0] fifo_q [DEPTH];
    logic [DATA_W-1:0] fifo_d [DEPTH];
    logic [CW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              err_q, err_d;
    logic              empty;

    assign io_in_rdy = (count_q < DEPTH_C);
    assign accept    = io_in_ren && io_in_rdy;
    assign drop      = io_in_ren && !io_in_rdy;
    // Read happens before this edge's write, so a colliding write returns old data
    assign rd_data   = mem_q[io_in_addr];

`ifdef REN_RESP_CLR_EN
    logic clr_all;
    assign clr_all = io_wen && (&io_waddr) && (&io_wdata);

    always_comb begin
        mem_d = mem_q;
        if (clr_all) begin
            for (int i = 0; i < WORDS; i++) mem_d[i] = '0;
        end else if (io_wen) begin
            mem_d[io_waddr] = io_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < WORDS; i++) mem_q[i] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end
`else
    always_comb begin
        mem_d = mem_q;
        if (io_wen) mem_d[io_waddr] = io_wdata;
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
`endif

    // The FIFO write is the final pipeline stage, so LAT-1 registers precede it
    generate
        if (LAT == 1) begin : g_lat1
            assign push_v = accept;
            assign push_d = rd_data;
        end else begin : g_pipe
            logic [LAT-2:0]    pv_q, pv_d;
            logic [DATA_W-1:0] pd_q [LAT-1];
            logic [DATA_W-1:0] pd_d [LAT-1];

            always_comb begin
                pv_d    = pv_q;
                pd_d    = pd_q;
                pv_d[0] = accept;
                pd_d[0] = rd_data;
                for (int k = 1; k < LAT - 1; k++) begin
                    pv_d[k] = pv_q[k-1];
                    pd_d[k] = pd_q[k-1];
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    pv_q <= '0;
                    for (int k = 0; k < LAT - 1; k++) pd_q[k] <= '0;
                end else begin
                    pv_q <= pv_d;
                    pd_q <= pd_d;
                end
            end

            assign push_v = pv_q[LAT-2];
            assign push_d = pd_q[LAT-2];
        end
    endgenerate

    assign empty        = (wr_ptr_q == rd_ptr_q);
    assign io_out_valid = !empty;
    assign io_out_data  = empty ? '0 : fifo_q[rd_ptr_q[FW-1:0]];
    assign pop          = io_out_valid && io_out_ready;
    assign io_count     = count_q;
    assign io_err       = err_q;

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        err_d    = err_q | drop;
        if (push_v) begin
            fifo_d[wr_ptr_q[FW-1:0]] = push_d;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({accept, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            fifo_q   <= fifo_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_ren_chain_responder.sv
// Randomized and directed bench for ren_chain_responder against a queue-based response model.
module tb_ren_chain_responder;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;
    localparam int WORDS = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          io_in_ren;
    logic [AW-1:0] io_in_addr;
    logic          io_in_rdy;
    logic          io_wen;
    logic [AW-1:0] io_waddr;
    logic [DW-1:0] io_wdata;
    logic          io_out_valid;
    logic          io_out_ready;
    logic [DW-1:0] io_out_data;
    logic [$clog2(DEPTH):0] io_count;
    logic          io_err;

    ren_chain_responder #(
        .ADDR_W(AW), .DATA_W(DW), .LAT(LAT), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset),
        .io_in_ren(io_in_ren), .io_in_addr(io_in_addr), .io_in_rdy(io_in_rdy),
        .io_wen(io_wen), .io_waddr(io_waddr), .io_wdata(io_wdata),
        .io_out_valid(io_out_valid), .io_out_ready(io_out_ready),
        .io_out_data(io_out_data), .io_count(io_count), .io_err(io_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference: storage image plus an ordered list of accepted requests
    logic [DW-1:0] mem_m [WORDS];
    int            q_cyc [$];
    logic [DW-1:0] q_dat [$];
    bit            err_m;
    int            cyc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic step(input bit ren, input int addr, input bit wen,
                        input int waddr, input int wdata, input bit rdy_in);
        bit            rdy_m, vld_m, acc;
        logic [DW-1:0] exp_d;
        @(negedge clk);
        io_in_ren    = ren;
        io_in_addr   = AW'(addr);
        io_wen       = wen;
        io_waddr     = AW'(waddr);
        io_wdata     = DW'(wdata);
        io_out_ready = rdy_in;
        #1;
        rdy_m = (q_cyc.size() < DEPTH);
        vld_m = (q_cyc.size() > 0) && (q_cyc[0] + LAT <= cyc);
        exp_d = vld_m ? q_dat[0] : '0;
        check("rdy", io_in_rdy, rdy_m);
        check("count", io_count, q_cyc.size());
        check("err", io_err, err_m);
        check("valid", io_out_valid, vld_m);
        check("data", io_out_data, exp_d);
        @(posedge clk);
        acc = ren && rdy_m;
        if (acc) begin
            q_cyc.push_back(cyc);
            q_dat.push_back(mem_m[AW'(addr)]);
        end
        if (ren && !rdy_m) err_m = 1'b1;
        if (vld_m && rdy_in) begin
            void'(q_cyc.pop_front());
            void'(q_dat.pop_front());
        end
        if (wen) begin
`ifdef REN_RESP_CLR_EN
            if (AW'(waddr) == {AW{1'b1}} && DW'(wdata) == {DW{1'b1}})
                for (int i = 0; i < WORDS; i++) mem_m[i] = '0;
            else
                mem_m[AW'(waddr)] = DW'(wdata);
`else
            mem_m[AW'(waddr)] = DW'(wdata);
`endif
        end
        cyc++;
    endtask

    task automatic idle(input int n, input bit rdy_in);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, rdy_in);
    endtask

    task automatic do_reset();
        @(negedge clk);
        io_in_ren = 0; io_wen = 0; io_out_ready = 0;
        reset = 1'b1;
        #1;
        check("rst_valid", io_out_valid, 1'b0);
        check("rst_count", io_count, 0);
        check("rst_rdy", io_in_rdy, 1'b1);
        check("rst_err", io_err, 1'b0);
        check("rst_data", io_out_data, 0);
        #2;
        reset = 1'b0;
        q_cyc.delete();
        q_dat.delete();
        err_m = 1'b0;
`ifdef REN_RESP_CLR_EN
        for (int i = 0; i < WORDS; i++) mem_m[i] = '0;
`endif
        @(posedge clk);
        cyc++;
    endtask

    initial begin
        reset = 1'b1;
        io_in_ren = 0; io_in_addr = '0; io_wen = 0;
        io_waddr = '0; io_wdata = '0; io_out_ready = 0;
        err_m = 1'b0;
        cyc = 0;
        for (int i = 0; i < WORDS; i++) mem_m[i] = '0;
        #12;
        check("init_valid", io_out_valid, 1'b0);
        check("init_count", io_count, 0);
        check("init_rdy", io_in_rdy, 1'b1);
        check("init_err", io_err, 1'b0);
        check("init_data", io_out_data, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < WORDS; i++) step(0, 0, 1, i, $urandom_range(0, 254), 1);

        // Basic read of 0x5A at addr 3
        step(0, 0, 1, 3, 8'h5A, 1);
        step(1, 3, 0, 0, 0, 1);
        idle(3, 1);

        // Collision: old data first, new data on the following read
        step(0, 0, 1, 7, 8'h11, 1);
        step(1, 7, 1, 7, 8'h22, 1);
        step(1, 7, 0, 0, 0, 1);
        idle(4, 1);

        // Streaming through the pointer wrap
        for (int i = 0; i < 40; i++) step(1, i % WORDS, 0, 0, 0, 1);
        idle(4, 1);
        check("stream_err", io_err, 1'b0);

        // Stall then drain
        for (int i = 0; i < 6; i++) step(1, i, 0, 0, 0, 0);
        check("stall_err", io_err, 1'b1);
        idle(8, 1);

        // Reset with three responses outstanding
        for (int i = 0; i < 3; i++) step(1, i + 4, 0, 0, 0, 0);
        do_reset();
        for (int i = 0; i < 4; i++) step(1, i, 0, 0, 0, 1);
        idle(4, 1);

        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 9) < 6, $urandom_range(0, WORDS - 1),
                 $urandom_range(0, 9) < 3, $urandom_range(0, WORDS - 1),
                 $urandom_range(0, 255), $urandom_range(0, 1));
            if (n == 200) do_reset();
        end
        idle(10, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
